// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters advanced by a pixel tick,
// with registered sync, blanking, coordinate and strobe outputs.
module vga_timing_gen #(
  parameter int unsigned H_DISP = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_PW   = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_DISP = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_PW   = 2,
  parameter int unsigned V_BP   = 29,
  parameter logic        HS_POL = 1'b0,
  parameter logic        VS_POL = 1'b0,
  parameter int unsigned CW     = 10,
  parameter int unsigned FCW    = 8
) (
  input  logic           vga_clk,
  input  logic           reset,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           disp_en,
  output logic [CW-1:0]  column,
  output logic [CW-1:0]  row,
  output logic           hblank,
  output logic           vblank,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_PW + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_PW + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_DISP);
  localparam logic [CW-1:0] H_SS   = CW'(H_DISP + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_DISP + H_FP + H_PW);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_DISP);
  localparam logic [CW-1:0] V_SS   = CW'(V_DISP + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_DISP + V_FP + V_PW);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          h_end;
  logic          v_end;
  logic          h_act;
  logic          v_act;
  logic          hs_on;
  logic          vs_on;

  // Decode of the current (pre-increment) counter position
  always_comb begin
    h_end = (h_cnt == H_LAST);
    v_end = (v_cnt == V_LAST);
    h_act = (h_cnt < H_ACT);
    v_act = (v_cnt < V_ACT);
    hs_on = (h_cnt >= H_SS) && (h_cnt < H_SE);
    vs_on = (v_cnt >= V_SS) && (v_cnt < V_SE);
    h_nxt = h_end ? '0 : h_cnt + CW'(1);
    v_nxt = v_cnt;
    if (h_end) begin
      v_nxt = v_end ? '0 : v_cnt + CW'(1);
    end
  end

  // Counters and outputs move only on a pixel tick; strobes self-clear otherwise
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      disp_en     <= 1'b0;
      column      <= '0;
      row         <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        if (h_end && v_end) begin
          frame_count <= frame_count + FCW'(1);
        end
        hsync       <= hs_on ? HS_POL : ~HS_POL;
        vsync       <= vs_on ? VS_POL : ~VS_POL;
        disp_en     <= h_act && v_act;
        column      <= (h_act && v_act) ? h_cnt : '0;
        row         <= (h_act && v_act) ? v_cnt : '0;
        hblank      <= ~h_act;
        vblank      <= ~v_act;
        line_start  <= (h_cnt == '0) && v_act;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule
